// File: rtl/sfifo_wr_arbiter.sv
// Round-robin write-port arbiter for a 32-deep sync FIFO.
// Grants one producer per burst; releases on last, burst cap or idle timeout.
module sfifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 32,
  parameter int BURST_MAX = 8,
  parameter int IDLE_TMO  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    i_valid,
  input  logic [NUM_REQ*DW-1:0] i_data,
  input  logic [NUM_REQ-1:0]    i_last,
  output logic [NUM_REQ-1:0]    o_ready,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic                  o_busy,
  output logic                  o_fifo_wr,
  output logic [DW-1:0]         o_fifo_data,
  input  logic                  i_fifo_full
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [3:0]           idle_q, idle_d;

  logic [PW-1:0]        pick;
  logic [PW-1:0]        cand;
  logic                 found;
  int                   idx;

  logic                 g_valid;
  logic                 g_last;
  logic [DW-1:0]        g_data;
  logic                 xfer;
  logic                 release_now;

  assign g_valid = i_valid[gidx_q];
  assign g_last  = i_last[gidx_q];
  assign g_data  = i_data[int'(gidx_q)*DW +: DW];
  assign o_grant = grant_q;
  assign o_busy  = (state_q == GRANT);

  // first requester at or after ptr, wrapping around
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PW'(idx);
      if (!found && i_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // next state, counters and the combinational write path
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    beat_d      = beat_q;
    idle_d      = idle_q;
    o_ready     = '0;
    o_fifo_wr   = 1'b0;
    o_fifo_data = '0;
    xfer        = 1'b0;
    release_now = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gidx_d  = pick;
          grant_d = NUM_REQ'(1) << pick;
          beat_d  = '0;
          idle_d  = '0;
        end
      end
      GRANT: begin
        o_ready[gidx_q] = ~i_fifo_full;
        xfer            = g_valid & ~i_fifo_full;
        o_fifo_wr       = xfer;
        if (xfer) o_fifo_data = g_data;
        if (xfer) begin
          beat_d = beat_q + 1'b1;
          idle_d = '0;
          if (g_last || (beat_q + 1'b1 == BW'(BURST_MAX)))
            release_now = 1'b1;
        end else if (!g_valid) begin
          idle_d = idle_q + 4'd1;
          if (idle_q + 4'd1 == 4'(IDLE_TMO))
            release_now = 1'b1;
        end
        if (release_now) begin
          state_d = IDLE;
          grant_d = '0;
          beat_d  = '0;
          idle_d  = '0;
          ptr_d   = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      beat_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
    end
  end

endmodule
